// File: rtl/rriot_bus_master.sv
// Host-side bus initiator for the RRIOT timer port: one read/write cycle per request,
// with OE-qualified data reads, a read timeout, and an independent irq edge counter.
module rriot_bus_master #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              per_enable,
    output logic              per_we_n,
    output logic [ADDR_W-1:0] per_A,
    output logic [7:0]        per_DI,
    input  logic [7:0]        per_DO,
    input  logic              per_OE,
    input  logic              per_irq,
    output logic              irq_pending,
    output logic [7:0]        irq_count,
    input  logic              irq_clear
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Only the parts of the request that steer the FSM after issue; address/data live on per_A/per_DI.
    typedef struct packed {
        logic we;
        logic status;
    } txn_t;

    state_t              state_q, state_d;
    txn_t                txn_q, txn_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                rsp_err_d;
    logic                per_enable_d;
    logic                per_we_n_d;
    logic [ADDR_W-1:0]   per_A_d;
    logic [DATA_W-1:0]   per_DI_d;

    logic                irq_prev;
    logic                irq_fall;

    // Transaction state and all bus/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            txn_q      <= '0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            per_enable <= 1'b0;
            per_we_n   <= 1'b1;
            per_A      <= '0;
            per_DI     <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            cnt_q      <= cnt_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
            per_enable <= per_enable_d;
            per_we_n   <= per_we_n_d;
            per_A      <= per_A_d;
            per_DI     <= per_DI_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready;
        rsp_valid_d  = rsp_valid;
        rsp_rdata_d  = rsp_rdata;
        rsp_err_d    = rsp_err;
        per_enable_d = per_enable;
        per_we_n_d   = per_we_n;
        per_A_d      = per_A;
        per_DI_d     = per_DI;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    txn_d.we     = req_we;
                    txn_d.status = req_addr[0];
                    per_A_d      = req_addr;
                    per_DI_d     = req_wdata;
                    per_we_n_d   = ~req_we;
                    per_enable_d = 1'b1;
                    req_ready_d  = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                per_enable_d = 1'b0;
                per_we_n_d   = 1'b1;
                if (txn_q.we) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Status registers never raise OE, so they are sampled on the first WAIT edge
                if (txn_q.status || per_OE) begin
                    rsp_rdata_d = per_DO;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_rdata_d = 8'hFF;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq_fall = irq_prev & ~per_irq;

    // Irq edge detector; a coincident clear restarts the count at this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev    <= 1'b1;
            irq_pending <= 1'b0;
            irq_count   <= '0;
        end else begin
            irq_prev <= per_irq;
            if (irq_fall) begin
                irq_pending <= 1'b1;
                if (irq_clear) begin
                    irq_count <= 8'd1;
                end else if (irq_count != 8'hFF) begin
                    irq_count <= irq_count + 8'd1;
                end
            end else if (irq_clear) begin
                irq_pending <= 1'b0;
                irq_count   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rriot_bus_master.sv
// Directed and randomized checks of rriot_bus_master against a latency/data model
// and a falling-edge irq counting model.
module tb_rriot_bus_master;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              per_enable;
    logic              per_we_n;
    logic [ADDR_W-1:0] per_A;
    logic [7:0]        per_DI;
    logic [7:0]        per_DO;
    logic              per_OE;
    logic              per_irq;
    logic              irq_pending;
    logic [7:0]        irq_count;
    logic              irq_clear;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt;
    bit m_pend;
    bit m_prev;

    rriot_bus_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .per_enable (per_enable),
        .per_we_n   (per_we_n),
        .per_A      (per_A),
        .per_DI     (per_DI),
        .per_DO     (per_DO),
        .per_OE     (per_OE),
        .per_irq    (per_irq),
        .irq_pending(irq_pending),
        .irq_count  (irq_count),
        .irq_clear  (irq_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input string tag);
        chk({tag, "_count"}, {24'd0, irq_count}, 32'(m_cnt));
        chk({tag, "_pending"}, {31'd0, irq_pending}, {31'd0, m_pend});
    endtask

    // One clock of irq stimulus; the model counts falling edges since the last clear
    task automatic irq_step(input logic lvl, input logic clr);
        per_irq   = lvl;
        irq_clear = clr;
        tick();
        if (m_prev && !lvl) begin
            m_pend = 1'b1;
            m_cnt  = clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
        end else if (clr) begin
            m_pend = 1'b0;
            m_cnt  = 0;
        end
        m_prev    = lvl;
        irq_clear = 1'b0;
    endtask

    // Full transaction; oe_k is the WAIT-cycle index at which OE is presented for data reads
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                           input int oe_k, input logic [7:0] dval, input int hold);
        int         lat;
        logic [7:0] exp_d;
        logic       exp_e;
        logic       exp_wen;
        if (we) begin
            lat = 1; exp_d = 8'h00; exp_e = 1'b0;
        end else if (addr[0]) begin
            lat = 2; exp_d = dval; exp_e = 1'b0;
        end else if (oe_k < int'(TIMEOUT)) begin
            lat = 2 + oe_k; exp_d = dval; exp_e = 1'b0;
        end else begin
            lat = 1 + int'(TIMEOUT); exp_d = 8'hFF; exp_e = 1'b1;
        end
        exp_wen = ~we;

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        chk("issue_enable", {31'd0, per_enable}, 32'd1);
        chk("issue_we_n", {31'd0, per_we_n}, {31'd0, exp_wen});
        chk("issue_addr", {29'd0, per_A}, {29'd0, addr});
        if (we) chk("issue_di", {24'd0, per_DI}, {24'd0, wdata});
        chk("issue_req_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        req_wdata = 8'($urandom);

        for (int c = 1; c <= lat; c++) begin
            if (!we && !addr[0]) begin
                per_OE = (c - 2 == oe_k);
                per_DO = (c - 2 == oe_k) ? dval : 8'($urandom);
            end else begin
                per_OE = 1'b0;
                per_DO = we ? 8'($urandom) : dval;
            end
            tick();
            chk("enable_one_cycle", {31'd0, per_enable}, 32'd0);
            chk("we_n_released", {31'd0, per_we_n}, 32'd1);
            chk("addr_held", {29'd0, per_A}, {29'd0, addr});
            if (c < lat) begin
                chk("rsp_not_early", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_d});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
            end
        end
        per_OE = 1'b0;

        for (int h = 0; h < hold; h++) begin
            per_DO = 8'($urandom);
            tick();
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", {24'd0, rsp_rdata}, {24'd0, exp_d});
            chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_e});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        per_DO    = '0;
        per_OE    = 1'b0;
        per_irq   = 1'b1;
        irq_clear = 1'b0;
        m_cnt     = 0;
        m_pend    = 1'b0;
        m_prev    = 1'b1;

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_per_enable", {31'd0, per_enable}, 32'd0);
        chk("rst_per_we_n", {31'd0, per_we_n}, 32'd1);
        chk("rst_per_A", {29'd0, per_A}, 32'd0);
        chk_irq("rst_irq");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_txn(1'b1, 3'b101, 8'h10, 0, 8'h00, 0);
        run_txn(1'b0, 3'b000, 8'h55, 0, 8'h3C, 1);
        run_txn(1'b0, 3'b001, 8'h00, 0, 8'h80, 0);
        run_txn(1'b0, 3'b000, 8'h00, int'(TIMEOUT) + 5, 8'h00, 5);
        run_txn(1'b0, 3'b010, 8'h00, int'(TIMEOUT) - 1, 8'hA7, 2);
        run_txn(1'b0, 3'b100, 8'h00, int'(TIMEOUT) - 2, 8'h5A, 0);

        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom), 3'($urandom), 8'($urandom),
                    int'($urandom_range(0, TIMEOUT + 3)), 8'($urandom),
                    int'($urandom_range(0, 3)));
            tick();
        end

        for (int i = 0; i < 3; i++) begin
            irq_step(1'b0, 1'b0);
            irq_step(1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) irq_step(1'b0, 1'b0);
        irq_step(1'b1, 1'b0);
        chk_irq("irq_four");
        chk("irq_count_is_4", {24'd0, irq_count}, 32'd4);
        irq_step(1'b0, 1'b1);
        chk_irq("irq_clear_edge");
        chk("irq_count_is_1", {24'd0, irq_count}, 32'd1);
        irq_step(1'b1, 1'b0);
        irq_step(1'b1, 1'b1);
        chk_irq("irq_cleared");

        for (int i = 0; i < 60; i++) begin
            irq_step(1'($urandom), ($urandom_range(0, 7) == 0));
            chk_irq("irq_rand");
        end
        irq_step(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            irq_step(1'b0, 1'b0);
            irq_step(1'b1, 1'b0);
        end
        chk_irq("irq_sat");
        chk("irq_count_is_ff", {24'd0, irq_count}, 32'hFF);

        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 3'b110;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_per_enable", {31'd0, per_enable}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_per_A", {29'd0, per_A}, 32'd0);
        m_cnt  = 0;
        m_pend = 1'b0;
        m_prev = 1'b1;
        chk_irq("arst_irq");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        run_txn(1'b1, 3'b011, 8'hC3, 0, 8'h00, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
